// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator measurement sequencer: enable one RO, settle, count its edges over a 2**GATE_LOG2 window.
// Optional build macro RO_AUTO_SCAN_EN: one start measures every RO back-to-back; otherwise a single RO per start.
module ro_measure_sequencer #(
  parameter int NUM_RO     = 8,
  parameter int CNT_W      = 16,
  parameter int GATE_LOG2  = 10,
  parameter int SETTLE_CYC = 4,
  parameter int IDX_W      = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  ro_sel,
  input  logic [NUM_RO-1:0] ro_clk,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [IDX_W-1:0]  cnt_idx,
  output logic              overflow,
  output logic              scan_done
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ST_W-1:0]      SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
  localparam logic [GATE_LOG2-1:0] GATE_LAST   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     sel_q;
  logic [NUM_RO-1:0]    ro_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CNT_W-1:0]     count_q;
  logic [IDX_W-1:0]     cnt_idx_q;
  logic                 overflow_q;
  logic [ST_W-1:0]      settle_q;
  logic [GATE_LOG2-1:0] gate_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic                 ro_mux;
  logic [IDX_W-1:0]     first_sel;

  function automatic logic sel_ok(input logic [IDX_W-1:0] s);
    return (int'(s) < NUM_RO);
  endfunction

  function automatic logic [NUM_RO-1:0] onehot(input logic [IDX_W-1:0] s);
    logic [NUM_RO-1:0] v;
    v = '0;
    if (sel_ok(s)) v[s] = 1'b1;
    return v;
  endfunction

  // Out-of-range index measures nothing: the mux feeds a constant 0 into the synchronizer.
  assign ro_mux = sel_ok(sel_q) ? ro_clk[sel_q] : 1'b0;

`ifdef RO_AUTO_SCAN_EN
  logic             scan_done_q;
  logic             last_ro;
  logic [IDX_W-1:0] next_sel;
  assign first_sel = '0;
  assign last_ro   = (sel_q == IDX_W'(NUM_RO - 1));
  assign next_sel  = sel_q + IDX_W'(1);
  assign scan_done = scan_done_q;
`else
  assign first_sel = ro_sel;
  assign scan_done = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (sync2_q && !prev_q) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      ro_en_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      cnt_idx_q  <= '0;
      overflow_q <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
`ifdef RO_AUTO_SCAN_EN
      scan_done_q <= 1'b0;
`endif
    end else begin
      sync1_q <= ro_mux;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      done_q  <= 1'b0;
`ifdef RO_AUTO_SCAN_EN
      scan_done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            sel_q    <= first_sel;
            ro_en_q  <= onehot(first_sel);
            busy_q   <= 1'b1;
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            ro_en_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (settle_q == SETTLE_LAST) begin
            gate_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_GATE;
          end else begin
            settle_q <= settle_q + ST_W'(1);
          end
        end
        S_GATE: begin
          if (abort) begin
            ro_en_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            gate_q <= gate_q + GATE_LOG2'(1);
            // Last window cycle: publish the count including this cycle's edge.
            if (gate_q == GATE_LAST) begin
              count_q    <= cnt_d;
              overflow_q <= ovf_d;
              cnt_idx_q  <= sel_q;
              done_q     <= 1'b1;
              ro_en_q    <= '0;
              state_q    <= S_DONE;
`ifdef RO_AUTO_SCAN_EN
              busy_q      <= 1'b1;
              scan_done_q <= last_ro;
`else
              busy_q      <= 1'b0;
`endif
            end
          end
        end
        S_DONE: begin
`ifdef RO_AUTO_SCAN_EN
          if (!abort && !last_ro) begin
            sel_q    <= next_sel;
            ro_en_q  <= onehot(next_sel);
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign cnt_idx  = cnt_idx_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Directed bench for ro_measure_sequencer (GATE_LOG2=4, SETTLE_CYC=4); a CNT_W=2 twin shares all inputs.
module tb_ro_measure_sequencer;
  localparam int NUM_RO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] ro_sel = '0;
  logic [7:0] ro_clk = '0;

  logic [7:0]  ro_en_a, ro_en_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, scan_a, scan_b;
  logic [15:0] count_a;
  logic [1:0]  count_b;
  logic [2:0]  idx_a, idx_b;

  ro_measure_sequencer #(.NUM_RO(NUM_RO), .CNT_W(16), .GATE_LOG2(4), .SETTLE_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_sel(ro_sel), .ro_clk(ro_clk),
    .ro_en(ro_en_a), .busy(busy_a), .done(done_a), .count(count_a), .cnt_idx(idx_a),
    .overflow(ovf_a), .scan_done(scan_a)
  );

  ro_measure_sequencer #(.NUM_RO(NUM_RO), .CNT_W(2), .GATE_LOG2(4), .SETTLE_CYC(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_sel(ro_sel), .ro_clk(ro_clk),
    .ro_en(ro_en_b), .busy(busy_b), .done(done_b), .count(count_b), .cnt_idx(idx_b),
    .overflow(ovf_b), .scan_done(scan_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [7:0] tog_mask = 8'h00;
  int tog_div = 2;
  int phase = 0;

  // RO stimulus: bits in tog_mask toggle every tog_div clk cycles, others held 0.
  always begin
    @(posedge clk);
    #2;
    phase++;
    if (phase % tog_div == 0) ro_clk = (ro_clk ^ tog_mask) & tog_mask;
    else                      ro_clk = ro_clk & tog_mask;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_a) done_cnt++;
    end
  endtask

  // Start at cycle 0; returns in cycle 1.
  task automatic start_meas(input logic [2:0] sel);
    ro_sel = sel;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // From cycle 1, runs to the done cycle (21) and checks the result.
  task automatic finish_meas(input string tag, input logic [15:0] exp_cnt,
                             input logic [2:0] exp_idx, input logic exp_ovf);
    tick(19);
    check({tag, "_nodone20"}, 32'(done_a), 32'd0);
    tick(1);
    check({tag, "_done21"}, 32'(done_a), 32'd1);
    check({tag, "_count"}, 32'(count_a), 32'(exp_cnt));
    check({tag, "_idx"}, 32'(idx_a), 32'(exp_idx));
    check({tag, "_ovf"}, 32'(ovf_a), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_ro_en", 32'(ro_en_a), 32'd0);
    check("rst_flags", {28'd0, busy_a, done_a, ovf_a, scan_a}, 32'd0);
    check("rst_count_idx", {13'd0, idx_a, count_a}, 32'd0);
    rst_n = 1'b1;
    tick(2);

`ifdef RO_AUTO_SCAN_EN
    tog_mask = 8'hFF; tog_div = 2;
    done_cnt = 0;
    start_meas(3'd6);
    for (int k = 0; k < 8; k++) begin
      tick((k == 0) ? 20 : 21);
      check("scan_done_pulse", 32'(done_a), 32'd1);
      check("scan_idx", 32'(idx_a), 32'(k));
      check("scan_last", 32'(scan_a), (k == 7) ? 32'd1 : 32'd0);
      check("scan_busy", 32'(busy_a), 32'd1);
    end
    tick(1);
    check("scan_busy_drop", 32'(busy_a), 32'd0);
    check("scan_done_total", 32'(done_cnt), 32'd8);
`else
    // 1: basic measurement, period-4 RO -> 4 edges in 16 cycles
    tog_mask = 8'h08; tog_div = 2;
    tick(4);
    start_meas(3'd3);
    check("t1_ro_en", 32'(ro_en_a), 32'h08);
    check("t1_busy", 32'(busy_a), 32'd1);
    finish_meas("t1", 16'd4, 3'd3, 1'b0);
    check("t1_done_ro_en", {23'd0, busy_a, ro_en_a}, 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_start_in_done", 32'(busy_a), 32'd0);
    tick(2);

    // 2: selected RO quiet while all others toggle, then all toggle
    tog_mask = 8'hF7;
    tick(3);
    start_meas(3'd3);
    finish_meas("t2a", 16'd0, 3'd3, 1'b0);
    tog_mask = 8'hFF;
    tick(3);
    start_meas(3'd3);
    finish_meas("t2b", 16'd4, 3'd3, 1'b0);

    // 3: toggle every cycle -> 8 edges; 2-bit twin saturates
    tog_mask = 8'h08; tog_div = 1;
    tick(3);
    start_meas(3'd3);
    finish_meas("t3", 16'd8, 3'd3, 1'b0);
    check("t3_sat_count", 32'(count_b), 32'd3);
    check("t3_sat_ovf", 32'(ovf_b), 32'd1);
    tick(2);

    // 4: restart during GATE is ignored
    tog_div = 2;
    tick(3);
    start_meas(3'd3);
    tick(9);
    ro_sel = 3'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t4_ro_en_kept", 32'(ro_en_a), 32'h08);
    tick(9);
    check("t4_nodone20", 32'(done_a), 32'd0);
    tick(1);
    check("t4_done21", 32'(done_a), 32'd1);
    check("t4_idx", 32'(idx_a), 32'd3);
    check("t4_count", 32'(count_a), 32'd4);
    tick(2);

    // 4b: abort in GATE, no done, outputs keep old values
    start_meas(3'd5);
    check("t4b_ro_en", 32'(ro_en_a), 32'h20);
    tick(9);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4b_abort_ro_en", {23'd0, busy_a, ro_en_a}, 32'd0);
    done_cnt = 0;
    tick(15);
    check("t4b_no_done", 32'(done_cnt), 32'd0);
    check("t4b_count_kept", 32'(count_a), 32'd4);
    check("t4b_idx_kept", 32'(idx_a), 32'd3);

    // 4c: abort and start in the same IDLE cycle
    abort = 1'b1;
    start_meas(3'd2);
    abort = 1'b0;
    check("t4c_abort_wins", {23'd0, busy_a, ro_en_a}, 32'd0);
    tick(2);

    // 5: asynchronous reset during GATE, then a clean measurement
    start_meas(3'd3);
    tick(9);
    rst_n = 1'b0;
    #1;
    check("t5_async_ro_en", {23'd0, busy_a, ro_en_a}, 32'd0);
    tick(2);
    check("t5_rst_count", {13'd0, idx_a, count_a}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    start_meas(3'd3);
    finish_meas("t5", 16'd4, 3'd3, 1'b0);
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
